// File: rtl/memshare_rdaddr_burst_gen.sv
// rtl/memshare_rdaddr_burst_gen.sv - sequential read-address burst generator for the message-pass buffer
// Accepts base/length requests and issues base+k (mod DEPTH) read beats with stall, abort and done status.
module memshare_rdaddr_burst_gen #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 96,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  rqst_valid_i,
  output logic                  rqst_ready_o,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  burst_len_i,
  input  logic                  abort_i,
  input  logic                  rd_stall_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  last_o,
  output logic                  done_o,
  output logic                  abort_o,
  output logic                  err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // One extra bit so DEPTH == 2^ADDR_WIDTH is still representable for the range check.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH:0]    beat_cnt_q, beat_cnt_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic                  err_q, err_d;
  logic                  accept;

  assign rqst_ready_o = (state_q == S_IDLE) && !rst;
  assign accept       = rqst_valid_i && rqst_ready_o;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = 1'b0;
    last_d      = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cur_addr_d  = base_addr_i;
          remaining_d = burst_len_i;
          beat_cnt_d  = '0;
          if ({1'b0, base_addr_i} >= DEPTH_EXT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (abort_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          abort_d = 1'b1;
        end else if (!rd_stall_i) begin
          rd_en_d    = 1'b1;
          rd_addr_d  = cur_addr_q;
          last_d     = (remaining_q == '0);
          cur_addr_d = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_WIDTH'(1);
          beat_cnt_d = beat_cnt_q + (LEN_WIDTH+1)'(1);
          // Final beat and done pulse land in the same cycle.
          if (remaining_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      last_q      <= last_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign last_o    = last_q;
  assign done_o    = done_q;
  assign abort_o   = abort_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_memshare_rdaddr_burst_gen.sv
// tb/tb_memshare_rdaddr_burst_gen.sv - self-checking bench for memshare_rdaddr_burst_gen
// Expected beats are (base+k) mod DEPTH, derived per edge from the bench's own stall/abort choices.
module tb_memshare_rdaddr_burst_gen;

  localparam int AW    = 7;
  localparam int DEPTH = 96;
  localparam int LW    = 4;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          rqst_valid_i = 1'b0;
  logic          rqst_ready_o;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] burst_len_i = '0;
  logic          abort_i = 1'b0;
  logic          rd_stall_i = 1'b0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic          last_o;
  logic          done_o;
  logic          abort_o;
  logic          err_o;
  logic [5:0]    obs;

  int n_checks = 0;
  int n_fails = 0;
  int mdl_last_addr = 0;

  memshare_rdaddr_burst_gen #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .rqst_valid_i(rqst_valid_i), .rqst_ready_o(rqst_ready_o),
    .base_addr_i(base_addr_i), .burst_len_i(burst_len_i),
    .abort_i(abort_i), .rd_stall_i(rd_stall_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .last_o(last_o),
    .done_o(done_o), .abort_o(abort_o), .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Status order: rd_en, last, done, abort, err, ready
  assign obs = {rd_en_o, last_o, done_o, abort_o, err_o, rqst_ready_o};

  task automatic run_burst(input int base, input int len, input logic [63:0] stall_mask,
                           input int stall_pct, input int abort_after, input bit stall_with_abort,
                           input string tag);
    int cyc, beats, dut_beats, edge_i, exp_addr, want_beats;
    bit fin, do_abort, do_stall, is_err;
    logic [5:0] exp_s;
    logic [63:0] sm;
    sm = stall_mask;
    cyc = 0;
    while (rqst_ready_o !== 1'b1 && cyc < 10) begin
      @(negedge sys_clk);
      cyc++;
    end
    n_checks++;
    if (rqst_ready_o !== 1'b1) begin
      n_fails++;
      $display("FAIL %s ready_timeout: ready=%b want 1", tag, rqst_ready_o);
      return;
    end
    is_err = (base >= DEPTH);
    rqst_valid_i = 1'b1;
    base_addr_i  = AW'(base);
    burst_len_i  = LW'(len);
    @(negedge sys_clk);
    rqst_valid_i = 1'b0;
    base_addr_i  = AW'($urandom);
    burst_len_i  = LW'($urandom);
    exp_s = is_err ? 6'b001010 : 6'b000000;
    n_checks++;
    if (obs !== exp_s) begin
      n_fails++;
      $display("FAIL %s accept status: got %b want %b", tag, obs, exp_s);
    end
    beats = 0;
    dut_beats = 0;
    fin = is_err;
    edge_i = 0;
    while (!fin && edge_i < 200) begin
      do_abort = (abort_after >= 0) && (beats == abort_after);
      do_stall = do_abort ? stall_with_abort : (sm[0] || (int'($urandom_range(99)) < stall_pct));
      sm = sm >> 1;
      abort_i = do_abort;
      rd_stall_i = do_stall;
      @(negedge sys_clk);
      edge_i++;
      if (rd_en_o === 1'b1) dut_beats++;
      if (do_abort) begin
        exp_s = 6'b001100;
        fin = 1'b1;
      end else if (do_stall) begin
        exp_s = 6'b000000;
        n_checks++;
        if (rd_addr_o !== AW'(mdl_last_addr)) begin
          n_fails++;
          $display("FAIL %s stall_hold edge%0d: rd_addr=%0d want %0d", tag, edge_i, rd_addr_o, mdl_last_addr);
        end
      end else begin
        exp_addr = (base + beats) % DEPTH;
        fin = (beats == len);
        exp_s = {1'b1, fin, fin, 3'b000};
        n_checks++;
        if (rd_addr_o !== AW'(exp_addr)) begin
          n_fails++;
          $display("FAIL %s beat%0d addr: got %0d want %0d", tag, beats, rd_addr_o, exp_addr);
        end
        mdl_last_addr = exp_addr;
        beats++;
      end
      n_checks++;
      if (obs !== exp_s) begin
        n_fails++;
        $display("FAIL %s edge%0d status: got %b want %b", tag, edge_i, obs, exp_s);
      end
    end
    abort_i = 1'b0;
    rd_stall_i = 1'b0;
    if (!fin) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s burst_timeout: beats=%0d want %0d", tag, beats, len + 1);
    end
    want_beats = is_err ? 0 : (abort_after >= 0 && abort_after <= len) ? abort_after : len + 1;
    n_checks++;
    if (dut_beats !== want_beats) begin
      n_fails++;
      $display("FAIL %s beat_count: got %0d want %0d", tag, dut_beats, want_beats);
    end
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fails++;
      $display("FAIL %s post_done status: got %b want 000001", tag, obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (obs !== 6'b000000 || rd_addr_o !== '0) begin
      n_fails++;
      $display("FAIL reset_state: status=%b addr=%0d want 000000 addr 0", obs, rd_addr_o);
    end
    rst = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fails++;
      $display("FAIL reset_release: status=%b want 000001", obs);
    end
  endtask

  task automatic test_basic();
    run_burst(10, 3, 64'd0, 0, -1, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_burst(94, 4, 64'd0, 0, -1, 1'b0, "wrap");
    run_burst(95, 0, 64'd0, 0, -1, 1'b0, "wrap_single");
  endtask

  task automatic test_stall();
    run_burst(0, 2, 64'b1110, 0, -1, 1'b0, "stall");
  endtask

  task automatic test_abort();
    run_burst(20, 15, 64'd0, 0, 5, 1'b0, "abort");
    run_burst(40, 6, 64'd0, 0, 3, 1'b1, "abort_stall");
    run_burst(60, 2, 64'd0, 0, 0, 1'b0, "abort_first");
  endtask

  task automatic test_error_maxlen();
    run_burst(100, 3, 64'd0, 0, -1, 1'b0, "error");
    run_burst(96, 0, 64'd0, 0, -1, 1'b0, "error_edge");
    run_burst(0, 15, 64'd0, 0, -1, 1'b0, "maxlen");
  endtask

  task automatic test_idle_abort();
    abort_i = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      n_checks++;
      if (obs !== 6'b000001) begin
        n_fails++;
        $display("FAIL idle_abort: status=%b want 000001", obs);
      end
    end
    abort_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base, len, ab;
    for (int i = 0; i < 25; i++) begin
      base = int'($urandom_range(DEPTH + 15));
      len  = int'($urandom_range(15));
      ab   = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
      run_burst(base, len, 64'd0, int'($urandom_range(50)), ab, 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    cyc = 0;
    while (rqst_ready_o !== 1'b1 && cyc < 10) begin
      @(negedge sys_clk);
      cyc++;
    end
    rqst_valid_i = 1'b1;
    base_addr_i  = 7'd30;
    burst_len_i  = 4'd15;
    @(negedge sys_clk);
    rqst_valid_i = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_checks++;
    if (rd_en_o !== 1'b1 || rd_addr_o !== 7'd31) begin
      n_fails++;
      $display("FAIL midrst_beat: rd_en=%b addr=%0d want 1 addr 31", rd_en_o, rd_addr_o);
    end
    rst = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 6'b000000 || rd_addr_o !== '0) begin
      n_fails++;
      $display("FAIL midrst_state: status=%b addr=%0d want 000000 addr 0", obs, rd_addr_o);
    end
    mdl_last_addr = 0;
    rst = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fails++;
      $display("FAIL midrst_no_done: status=%b want 000001", obs);
    end
    run_burst(5, 0, 64'd0, 0, -1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_abort();
    test_error_maxlen();
    test_idle_abort();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memshare_rdaddr_burst_gen.md
Name: memshare_rdaddr_burst_gen

Overview:
- Downstream of the memShare request-address rebase stage.
- Takes the rebased message-pass buffer base address plus a beat count and issues a burst of sequential read addresses (base+offset, wrapped modulo buffer depth) to the message-pass buffer read port.
- Provides a valid/ready request handshake, downstream stall, abort, and a done/error status pulse to the SCU.memShare() scheduler.

Parameters:
ADDR_WIDTH, 7, read address width (matches MSGPASS_RD_ADDR_WIDTH)
DEPTH, 96, message-pass buffer depth in words; addresses wrap modulo DEPTH; 2 <= DEPTH <= 2^ADDR_WIDTH
LEN_WIDTH, 4, width of burst length field; beats = burst_len_i+1 (1..2^LEN_WIDTH)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
rqst_valid_i  input  1  burst request valid
rqst_ready_o  output  1  block can accept a request
base_addr_i  input  ADDR_WIDTH  base address from rebase stage, sampled on handshake
burst_len_i  input  LEN_WIDTH  beats minus one, sampled on handshake
abort_i  input  1  terminate current burst
rd_stall_i  input  1  read port back-pressure; no beat launched while high
rd_en_o  output  1  read enable, registered
rd_addr_o  output  ADDR_WIDTH  read address, registered, valid when rd_en_o=1
last_o  output  1  marks final beat of burst, registered
done_o  output  1  one-cycle burst-complete pulse
abort_o  output  1  qualifies done_o: burst ended by abort
err_o  output  1  qualifies done_o: base_addr_i >= DEPTH at handshake

Behaviour:
- Clock and reset: one clock, sys_clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE; rd_en_o, rd_addr_o, last_o, done_o, abort_o, err_o, beat counter and internal address all 0. rqst_ready_o=0 while rst=1.
- FSM states: IDLE, ISSUE, DONE. rqst_ready_o = (state==IDLE) & !rst.
- Handshake: accepted at an edge where rqst_valid_i & rqst_ready_o.
  - On accept, latch base_addr_i into cur_addr, burst_len_i into remaining, clear beat_cnt.
  - If base_addr_i >= DEPTH, go to DONE with err_o=1 and issue no beats.
  - Otherwise go to ISSUE.
  - Inputs are ignored when not ready. Request fields must be held stable only during the handshake cycle.
- ISSUE, each edge:
  - abort_i=1 has priority over stall. Go to DONE with abort_o=1; no beat is launched that edge. Beats already launched are not retracted.
  - Else if rd_stall_i=1, hold everything and drive rd_en_o=0, last_o=0. rd_addr_o keeps its last value.
  - Else launch a beat: rd_en_o<=1, rd_addr_o<=cur_addr, last_o<=(remaining==0).
    - cur_addr <= (cur_addr==DEPTH-1) ? 0 : cur_addr+1. This is modulo DEPTH, not 2^ADDR_WIDTH.
    - If remaining==0, go to DONE. Else remaining<=remaining-1.
- Outside launching edges, rd_en_o and last_o are registered to 0.
- DONE lasts exactly 1 cycle, then returns to IDLE.
  - done_o=1 during the DONE cycle. abort_o and err_o are valid only while done_o=1 and are 0 otherwise.
  - Normal completion: done_o is coincident with the final rd_en_o/last_o cycle.
- Latency:
  - Handshake edge E0.
  - First beat visible in the cycle after E1, assuming no stall at E1.
  - Back-to-back bursts: the next handshake is possible one cycle after DONE, i.e. a 2-cycle gap between bursts.
- Unsupported: simultaneous abort_i in IDLE or DONE is ignored.
- Reset mid-burst: aborts immediately to reset values, with no done_o pulse.
- Arithmetic: the wrap comparison is on the full ADDR_WIDTH. DEPTH = 2^ADDR_WIDTH must degenerate to natural wrap.

Test Plan:
- Basic burst: base=10, len=3, no stall -> rd_addr 10,11,12,13 on 4 consecutive cycles; last_o with 13; done_o coincident; rqst_ready_o low from accept until the cycle after done.
- Wrap: base=94, len=4 -> addresses 94,95,0,1,2; last_o on 2; no address >= 96 ever driven.
- Stall: base=0, len=2, rd_stall_i high for 3 cycles after the first beat -> rd_en_o low for those 3 cycles, then addresses 1,2 resume; exactly 3 beats total.
- Abort: base=20, len=15, abort_i pulsed after 5 beats -> addresses 20..24 only; done_o=1 with abort_o=1 next cycle; abort and stall together -> abort wins.
- Error and max length: base=100 -> zero beats, done_o=1 with err_o=1 one cycle after accept. base=0, len=15 -> 16 beats 0..15.
- Reset: rst asserted mid-burst -> next cycle all outputs 0, rqst_ready_o=0; after release, a new request (base=5, len=0) yields a single beat at 5 with last_o and done_o.
